pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 16 +
 rtl/sync_edge.sv | 46 ++++
 rtl/pwm_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM encoding and the nominal period
// common to the 8-bit PWM generator and the capture block.
package pwm_pkg;

  localparam int unsigned PWM_PERIOD_NOM = 256;
  localparam int unsigned DUTY_W         = 8;
  localparam int unsigned DUTY_MAX       = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_LOST = 2'd3
  } cap_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus registered edge detector; rise/fall are
// single-cycle pulses aligned with the level they report.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = pwm_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of pwm_in,
// publishing a report on every completed period or on input loss.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PERIOD_NOM = PWM_PERIOD_NOM,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              valid,
  output logic              period_err,
  output logic              timeout
);

  localparam int unsigned       IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

  logic lvl, rise, fall;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  high_lat_q, high_lat_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    high_lat_d = high_lat_q;
    idle_d     = (rise || fall) ? '0
               : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1));
    duty_d     = duty_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          high_lat_d = cnt_q;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        // Rise closes the period: cnt_q holds the rise-to-rise distance.
        if (rise) begin
          duty_d   = (high_lat_q > CNT_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX)
                                                     : high_lat_q[DUTY_W-1:0];
          high_d   = high_lat_q;
          period_d = cnt_q;
          perr_d   = (cnt_q != CNT_W'(PERIOD_NOM));
          valid_d  = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_HIGH;
        end
      end
      ST_LOST: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          tmo_d   = 1'b0;
          state_d = ST_HIGH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Input loss; cannot coincide with an edge since edges clear idle_d.
    if (state_q != ST_LOST && idle_d == IDLE_W'(TIMEOUT)) begin
      state_d  = ST_LOST;
      tmo_d    = 1'b1;
      valid_d  = 1'b1;
      period_d = '0;
      perr_d   = 1'b0;
      if (lvl) begin
        duty_d = DUTY_W'(DUTY_MAX);
        high_d = cnt_d;
      end else begin
        duty_d = '0;
        high_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      high_lat_q <= '0;
      idle_q     <= '0;
      duty_q     <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      idle_q     <= idle_d;
      duty_q     <= duty_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      tmo_q      <= tmo_d;
    end
  end

  assign duty_out   = duty_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign valid      = valid_q;
  assign period_err = perr_q;
  assign timeout    = tmo_q;

endmodule
